// File: rtl/reg_alias_table_mp.sv
// reg_alias_table_mp: multi-port RAT with in-group bypass, tag-checked commit, flush and optional snapshot (RAT_CHECKPOINT_EN)
module reg_alias_table_mp #(
  parameter int NUM_ARCH = 32,
  parameter int AW = 5,
  parameter int TAG_W = 5,
  parameter int N_RN = 2,
  parameter int N_CM = 2
) (
  input  logic                  clk,
  input  logic                  rst_ni,
  input  logic [N_RN-1:0]       rn_valid_i,
  input  logic [N_RN*AW-1:0]    rn_rs_i,
  input  logic [N_RN*AW-1:0]    rn_rt_i,
  input  logic [N_RN*AW-1:0]    rn_dest_i,
  input  logic [N_RN*TAG_W-1:0] rn_tag_i,
  output logic [N_RN*TAG_W-1:0] rs_tag_o,
  output logic [N_RN*TAG_W-1:0] rt_tag_o,
  output logic [N_RN-1:0]       rs_busy_o,
  output logic [N_RN-1:0]       rt_busy_o,
  input  logic [N_CM-1:0]       cm_valid_i,
  input  logic [N_CM*AW-1:0]    cm_dest_i,
  input  logic [N_CM*TAG_W-1:0] cm_tag_i,
  input  logic                  flush_i,
  input  logic                  ckpt_save_i,
  input  logic                  ckpt_restore_i,
  output logic                  ckpt_valid_o
);
  logic [NUM_ARCH-1:0] busy_q, busy_d, cm_b, rn_b, snap_b;
  logic [NUM_ARCH-1:0][TAG_W-1:0] tag_q, tag_d, cm_t, rn_t, snap_t;
  logic restore;
  for (genvar j = 0; j < N_RN; j++) begin : g_lk
    logic [AW-1:0] s, t;
    logic sb, tb;
    logic [TAG_W-1:0] st, tt;
    assign s = rn_rs_i[j*AW +: AW];
    assign t = rn_rt_i[j*AW +: AW];
    // Source lookup: youngest older slot writing the register wins, else the table; forced idle in reset
    always_comb begin
      sb = busy_q[s];
      st = tag_q[s];
      tb = busy_q[t];
      tt = tag_q[t];
      for (int i = 0; i < j; i++) begin
        if (rn_valid_i[i] && rn_dest_i[i*AW +: AW] != '0 && rn_dest_i[i*AW +: AW] == s) begin
          sb = 1'b1;
          st = rn_tag_i[i*TAG_W +: TAG_W];
        end
        if (rn_valid_i[i] && rn_dest_i[i*AW +: AW] != '0 && rn_dest_i[i*AW +: AW] == t) begin
          tb = 1'b1;
          tt = rn_tag_i[i*TAG_W +: TAG_W];
        end
      end
      if (s == '0 || !rst_ni) begin
        sb = 1'b0;
        st = '0;
      end
      if (t == '0 || !rst_ni) begin
        tb = 1'b0;
        tt = '0;
      end
    end
    assign rs_busy_o[j] = sb;
    assign rt_busy_o[j] = tb;
    assign rs_tag_o[j*TAG_W +: TAG_W] = st;
    assign rt_tag_o[j*TAG_W +: TAG_W] = tt;
  end
  // Retire: clear an entry only while it still holds the retiring tag
  always_comb begin
    cm_b = busy_q;
    cm_t = tag_q;
    for (int j = 0; j < N_CM; j++)
      if (cm_valid_i[j] && cm_dest_i[j*AW +: AW] != '0 && busy_q[cm_dest_i[j*AW +: AW]]
          && tag_q[cm_dest_i[j*AW +: AW]] == cm_tag_i[j*TAG_W +: TAG_W]) begin
        cm_b[cm_dest_i[j*AW +: AW]] = 1'b0;
        cm_t[cm_dest_i[j*AW +: AW]] = '0;
      end
  end
  // Rename on top of retire; later slots overwrite earlier ones so the youngest wins
  always_comb begin
    rn_b = cm_b;
    rn_t = cm_t;
    for (int i = 0; i < N_RN; i++)
      if (rn_valid_i[i] && rn_dest_i[i*AW +: AW] != '0) begin
        rn_b[rn_dest_i[i*AW +: AW]] = 1'b1;
        rn_t[rn_dest_i[i*AW +: AW]] = rn_tag_i[i*TAG_W +: TAG_W];
      end
  end
  // Table next state: flush beats restore beats normal update
  always_comb begin
    busy_d = flush_i ? '0 : restore ? snap_b : rn_b;
    tag_d = flush_i ? '0 : restore ? snap_t : rn_t;
  end
  // Table state; entry 0 is never written so it stays zero
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q <= '0;
      tag_q <= '0;
    end else begin
      busy_q <= busy_d;
      tag_q <= tag_d;
    end
  end
`ifdef RAT_CHECKPOINT_EN
  logic ckv_q, ckv_d, save;
  logic [NUM_ARCH-1:0] sb_q, sb_d;
  logic [NUM_ARCH-1:0][TAG_W-1:0] st_q, st_d;
  assign restore = ckpt_restore_i & ckv_q;
  // Retire against the snapshot too, so a restore never revives a committed tag
  always_comb begin
    snap_b = sb_q;
    snap_t = st_q;
    for (int j = 0; j < N_CM; j++)
      if (cm_valid_i[j] && cm_dest_i[j*AW +: AW] != '0 && sb_q[cm_dest_i[j*AW +: AW]]
          && st_q[cm_dest_i[j*AW +: AW]] == cm_tag_i[j*TAG_W +: TAG_W]) begin
        snap_b[cm_dest_i[j*AW +: AW]] = 1'b0;
        snap_t[cm_dest_i[j*AW +: AW]] = '0;
      end
  end
  // Snapshot capture of the full next table, otherwise hold the retire-cleaned copy
  always_comb begin
    save = ckpt_save_i & ~flush_i & ~restore;
    sb_d = save ? rn_b : snap_b;
    st_d = save ? rn_t : snap_t;
    ckv_d = (flush_i | restore) ? 1'b0 : save ? 1'b1 : ckv_q;
  end
  // Snapshot storage and its valid flag
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      sb_q <= '0;
      st_q <= '0;
      ckv_q <= 1'b0;
    end else begin
      sb_q <= sb_d;
      st_q <= st_d;
      ckv_q <= ckv_d;
    end
  end
  assign ckpt_valid_o = ckv_q;
`else
  logic unused_ckpt;
  assign unused_ckpt = ckpt_save_i ^ ckpt_restore_i;
  assign restore = 1'b0;
  assign snap_b = '0;
  assign snap_t = '0;
  assign ckpt_valid_o = 1'b0;
`endif
endmodule

// File: tb/tb_reg_alias_table_mp.sv
// tb_reg_alias_table_mp: vector table, corner sequences and randomized run against a behavioural RAT model
module tb_reg_alias_table_mp;
  localparam int NA = 32, AW = 5, TW = 5, NR = 2, NC = 2;
  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  logic [NR-1:0] rn_valid_i;
  logic [NR*AW-1:0] rn_rs_i, rn_rt_i, rn_dest_i;
  logic [NR*TW-1:0] rn_tag_i, rs_tag_o, rt_tag_o;
  logic [NR-1:0] rs_busy_o, rt_busy_o;
  logic [NC-1:0] cm_valid_i;
  logic [NC*AW-1:0] cm_dest_i;
  logic [NC*TW-1:0] cm_tag_i;
  logic flush_i, ckpt_save_i, ckpt_restore_i, ckpt_valid_o;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  reg_alias_table_mp dut (
    .clk(clk), .rst_ni(rst_ni), .rn_valid_i(rn_valid_i), .rn_rs_i(rn_rs_i), .rn_rt_i(rn_rt_i),
    .rn_dest_i(rn_dest_i), .rn_tag_i(rn_tag_i), .rs_tag_o(rs_tag_o), .rt_tag_o(rt_tag_o),
    .rs_busy_o(rs_busy_o), .rt_busy_o(rt_busy_o), .cm_valid_i(cm_valid_i), .cm_dest_i(cm_dest_i),
    .cm_tag_i(cm_tag_i), .flush_i(flush_i), .ckpt_save_i(ckpt_save_i),
    .ckpt_restore_i(ckpt_restore_i), .ckpt_valid_o(ckpt_valid_o)
  );

  int v[NR], d[NR], tg[NR], rs[NR], rt[NR], cv[NC], cd[NC], ct[NC];
  int fl, sv, rr;
  bit mb[NA], sb[NA], mckv;
  int mt[NA], st[NA];

  typedef struct packed {
    int v, d0, t0, d1, t1, s0, r0, s1, r1, cv, c0, k0, c1, k1;
    int e0, e1, e2, e3, e4, e5, e6, e7;
  } tv_t;
  tv_t tv[11];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic idle();
    for (int i = 0; i < NR; i++) begin
      v[i] = 0; d[i] = 0; tg[i] = 0; rs[i] = 0; rt[i] = 0;
    end
    for (int i = 0; i < NC; i++) begin
      cv[i] = 0; cd[i] = 0; ct[i] = 0;
    end
    fl = 0; sv = 0; rr = 0;
  endtask

  task automatic apply();
    for (int i = 0; i < NR; i++) begin
      rn_valid_i[i] = (v[i] != 0);
      rn_dest_i[i*AW +: AW] = AW'(d[i]);
      rn_tag_i[i*TW +: TW] = TW'(tg[i]);
      rn_rs_i[i*AW +: AW] = AW'(rs[i]);
      rn_rt_i[i*AW +: AW] = AW'(rt[i]);
    end
    for (int i = 0; i < NC; i++) begin
      cm_valid_i[i] = (cv[i] != 0);
      cm_dest_i[i*AW +: AW] = AW'(cd[i]);
      cm_tag_i[i*TW +: TW] = TW'(ct[i]);
    end
    flush_i = (fl != 0);
    ckpt_save_i = (sv != 0);
    ckpt_restore_i = (rr != 0);
  endtask

  function automatic void mclear();
    for (int i = 0; i < NA; i++) begin
      mb[i] = 0; mt[i] = 0; sb[i] = 0; st[i] = 0;
    end
    mckv = 0;
  endfunction

  function automatic void mlook(int j, int s, output bit b, output int t);
    b = mb[s];
    t = mt[s];
    for (int i = 0; i < j; i++)
      if (v[i] != 0 && d[i] != 0 && d[i] == s) begin
        b = 1; t = tg[i];
      end
    if (s == 0 || !rst_ni) begin
      b = 0; t = 0;
    end
  endfunction

  task automatic cmp_model();
    logic [NR-1:0] ebs, ebt;
    logic [NR*TW-1:0] ets, ett;
    bit b;
    int t;
    for (int j = 0; j < NR; j++) begin
      mlook(j, rs[j], b, t);
      ebs[j] = b; ets[j*TW +: TW] = TW'(t);
      mlook(j, rt[j], b, t);
      ebt[j] = b; ett[j*TW +: TW] = TW'(t);
    end
    chk("model_rs_busy", 32'(rs_busy_o), 32'(ebs));
    chk("model_rs_tag", 32'(rs_tag_o), 32'(ets));
    chk("model_rt_busy", 32'(rt_busy_o), 32'(ebt));
    chk("model_rt_tag", 32'(rt_tag_o), 32'(ett));
    chk("model_ckpt_valid", 32'(ckpt_valid_o), 32'(mckv));
  endtask

  function automatic void mstep();
    for (int j = 0; j < NC; j++)
      if (cv[j] != 0 && cd[j] != 0) begin
        if (mb[cd[j]] && mt[cd[j]] == ct[j]) begin
          mb[cd[j]] = 0; mt[cd[j]] = 0;
        end
        if (mckv && sb[cd[j]] && st[cd[j]] == ct[j]) begin
          sb[cd[j]] = 0; st[cd[j]] = 0;
        end
      end
    if (fl != 0) begin
      for (int i = 0; i < NA; i++) begin
        mb[i] = 0; mt[i] = 0;
      end
      mckv = 0;
    end
`ifdef RAT_CHECKPOINT_EN
    else if (rr != 0 && mckv) begin
      mb = sb; mt = st; mckv = 0;
    end
`endif
    else begin
      for (int i = 0; i < NR; i++)
        if (v[i] != 0 && d[i] != 0) begin
          mb[d[i]] = 1; mt[d[i]] = tg[i];
        end
`ifdef RAT_CHECKPOINT_EN
      if (sv != 0) begin
        sb = mb; st = mt; mckv = 1;
      end
`endif
    end
  endfunction

  task automatic cyc();
    apply();
    #1;
    cmp_model();
    @(posedge clk);
    mstep();
    @(negedge clk);
  endtask

  task automatic look(string nm, int r, int eb, int et);
    idle();
    rs[0] = r;
    apply();
    #1;
    chk({nm, "_busy"}, 32'(rs_busy_o[0]), eb);
    chk({nm, "_tag"}, 32'(rs_tag_o[TW-1:0]), et);
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle();
    apply();
    rst_ni = 1'b0;
    mclear();
    #1;
    cmp_model();
    @(negedge clk);
    rst_ni = 1'b1;
    #1;
    cmp_model();
    @(negedge clk);
  endtask

  initial begin
    tv[0]  = '{1, 5, 9, 0, 0,   5, 0, 5, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 1, 9, 0, 0};
    tv[1]  = '{1, 3, 4, 0, 0,   5, 5, 3, 7, 0, 0, 0, 0, 0,   1, 9, 1, 9, 1, 4, 0, 0};
    tv[2]  = '{3, 8, 10, 8, 11, 3, 8, 8, 5, 0, 0, 0, 0, 0,   1, 4, 0, 0, 1, 10, 1, 9};
    tv[3]  = '{1, 5, 12, 0, 0,  8, 5, 5, 0, 0, 0, 0, 0, 0,   1, 11, 1, 9, 1, 12, 0, 0};
    tv[4]  = '{0, 0, 0, 0, 0,   5, 3, 0, 0, 1, 5, 9, 0, 0,   1, 12, 1, 4, 0, 0, 0, 0};
    tv[5]  = '{0, 0, 0, 0, 0,   5, 8, 5, 0, 1, 5, 12, 0, 0,  1, 12, 1, 11, 1, 12, 0, 0};
    tv[6]  = '{1, 5, 12, 0, 0,  5, 3, 5, 8, 0, 0, 0, 0, 0,   0, 0, 1, 4, 1, 12, 1, 11};
    tv[7]  = '{1, 5, 13, 0, 0,  5, 0, 5, 3, 1, 5, 12, 0, 0,  1, 12, 0, 0, 1, 13, 1, 4};
    tv[8]  = '{1, 0, 6, 0, 0,   5, 0, 0, 5, 0, 0, 0, 0, 0,   1, 13, 0, 0, 0, 0, 1, 13};
    tv[9]  = '{0, 0, 0, 0, 0,   0, 0, 3, 8, 3, 3, 4, 8, 11,  0, 0, 0, 0, 1, 4, 1, 11};
    tv[10] = '{0, 0, 0, 0, 0,   3, 8, 5, 7, 0, 0, 0, 0, 0,   0, 0, 0, 0, 1, 13, 0, 0};
    do_reset();
    foreach (tv[n]) begin
      idle();
      v[0] = tv[n].v & 1; v[1] = (tv[n].v >> 1) & 1;
      d[0] = tv[n].d0; tg[0] = tv[n].t0; d[1] = tv[n].d1; tg[1] = tv[n].t1;
      rs[0] = tv[n].s0; rt[0] = tv[n].r0; rs[1] = tv[n].s1; rt[1] = tv[n].r1;
      cv[0] = tv[n].cv & 1; cv[1] = (tv[n].cv >> 1) & 1;
      cd[0] = tv[n].c0; ct[0] = tv[n].k0; cd[1] = tv[n].c1; ct[1] = tv[n].k1;
      apply();
      #1;
      chk($sformatf("row%0d_rs0_busy", n), 32'(rs_busy_o[0]), tv[n].e0);
      chk($sformatf("row%0d_rs0_tag", n), 32'(rs_tag_o[4:0]), tv[n].e1);
      chk($sformatf("row%0d_rt0_busy", n), 32'(rt_busy_o[0]), tv[n].e2);
      chk($sformatf("row%0d_rt0_tag", n), 32'(rt_tag_o[4:0]), tv[n].e3);
      chk($sformatf("row%0d_rs1_busy", n), 32'(rs_busy_o[1]), tv[n].e4);
      chk($sformatf("row%0d_rs1_tag", n), 32'(rs_tag_o[9:5]), tv[n].e5);
      chk($sformatf("row%0d_rt1_busy", n), 32'(rt_busy_o[1]), tv[n].e6);
      chk($sformatf("row%0d_rt1_tag", n), 32'(rt_tag_o[9:5]), tv[n].e7);
      cmp_model();
      @(posedge clk);
      mstep();
      @(negedge clk);
    end
    idle(); v[0] = 1; d[0] = 2; tg[0] = 1; v[1] = 1; d[1] = 3; tg[1] = 2; cyc();
    idle(); fl = 1; v[0] = 1; d[0] = 4; tg[0] = 9; cyc();
    look("flush_r2", 2, 0, 0);
    look("flush_r4", 4, 0, 0);
`ifdef RAT_CHECKPOINT_EN
    do_reset();
    idle(); v[0] = 1; d[0] = 2; tg[0] = 1; cyc();
    idle(); sv = 1; cyc();
    chk("ckv_set", 32'(ckpt_valid_o), 1);
    idle(); v[0] = 1; d[0] = 2; tg[0] = 3; v[1] = 1; d[1] = 4; tg[1] = 5; cyc();
    idle(); cv[0] = 1; cd[0] = 2; ct[0] = 1; cyc();
    look("pre_restore_r2", 2, 1, 3);
    idle(); rr = 1; cyc();
    chk("ckv_clr_restore", 32'(ckpt_valid_o), 0);
    look("restore_r2", 2, 0, 0);
    look("restore_r4", 4, 0, 0);
    idle(); v[0] = 1; d[0] = 2; tg[0] = 1; cyc();
    idle(); sv = 1; cyc();
    idle(); v[0] = 1; d[0] = 2; tg[0] = 3; v[1] = 1; d[1] = 4; tg[1] = 5; cyc();
    idle(); rr = 1; fl = 1; cyc();
    chk("ckv_clr_flush", 32'(ckpt_valid_o), 0);
    look("flushrr_r2", 2, 0, 0);
    look("flushrr_r4", 4, 0, 0);
    idle(); rr = 1; v[0] = 1; d[0] = 6; tg[0] = 7; cyc();
    look("rr_nockpt_r6", 6, 1, 7);
    idle(); v[0] = 1; d[0] = 9; tg[0] = 20; sv = 1; cyc();
    idle(); v[0] = 1; d[0] = 9; tg[0] = 21; cyc();
    idle(); rr = 1; v[0] = 1; d[0] = 10; tg[0] = 22; cyc();
    look("save_ren_r9", 9, 1, 20);
    look("rr_drop_r10", 10, 0, 0);
    idle(); sv = 1; cyc();
`else
    idle(); sv = 1; cyc();
    chk("ckv_off", 32'(ckpt_valid_o), 0);
    idle(); rr = 1; v[0] = 1; d[0] = 6; tg[0] = 7; cyc();
    look("rr_ign_r6", 6, 1, 7);
`endif
    idle(); v[0] = 1; d[0] = 4; tg[0] = 7; v[1] = 1; d[1] = 6; tg[1] = 8; rs[1] = 4; rt[0] = 6;
    apply();
    #1;
    cmp_model();
    rst_ni = 1'b0;
    mclear();
    #1;
    chk("arst_rs_busy", 32'(rs_busy_o), 0);
    chk("arst_rs_tag", 32'(rs_tag_o), 0);
    chk("arst_rt_busy", 32'(rt_busy_o), 0);
    chk("arst_rt_tag", 32'(rt_tag_o), 0);
    chk("arst_ckv", 32'(ckpt_valid_o), 0);
    @(negedge clk);
    rst_ni = 1'b1;
    look("arst_r4", 4, 0, 0);
    look("arst_r6", 6, 0, 0);
    for (int n = 0; n < 1500; n++) begin
      int k;
      idle();
      for (int i = 0; i < NR; i++) begin
        v[i] = $urandom_range(0, 3) != 0;
        d[i] = $urandom_range(0, 7);
        tg[i] = $urandom_range(0, 31);
        rs[i] = $urandom_range(0, 7);
        rt[i] = $urandom_range(0, 7);
      end
      for (int i = 0; i < NC; i++) begin
        cv[i] = $urandom_range(0, 1);
        cd[i] = $urandom_range(0, 7);
        k = $urandom_range(0, 2);
        ct[i] = k == 0 ? mt[cd[i]] : k == 1 ? st[cd[i]] : int'($urandom_range(0, 31));
      end
      fl = $urandom_range(0, 39) == 0;
      sv = $urandom_range(0, 9) == 0;
      rr = $urandom_range(0, 11) == 0;
      cyc();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/reg_alias_table_mp.md
# reg_alias_table_mp

Multi-port register alias table for the out-of-order core: maps each architectural register to the ROB tag of its youngest in-flight producer. It serves N_RN rename slots per cycle, including intra-group dependency bypass, and retires mappings through N_CM commit ports. A stale commit cannot clear a newer mapping. Sits between decode/rename and the ROB/reservation stations, with full-flush and single-checkpoint recovery.

## Interface
Parameters:
- NUM_ARCH, 32, architectural register count; register 0 is hardwired zero and never renamed
- AW, 5, architectural index width (clog2 NUM_ARCH)
- TAG_W, 5, ROB tag width
- N_RN, 2, rename slots per cycle; slot 0 is oldest
- N_CM, 2, commit ports per cycle

Ports (per-slot buses flattened, slot i at bits [i*W +: W]):
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low
- rn_valid  in  N_RN  slot i carries a renaming instruction
- rn_rs, rn_rt  in  N_RN*AW  source architectural indices
- rn_dest  in  N_RN*AW  destination index; 0 means no destination
- rn_tag  in  N_RN*TAG_W  ROB tag allocated to slot i
- rs_tag, rt_tag  out  N_RN*TAG_W  producer tag per source; 0 when not busy
- rs_busy, rt_busy  out  N_RN  source is awaiting an in-flight producer
- cm_valid  in  N_CM  commit port j retiring an instruction
- cm_dest  in  N_CM*AW  retiring destination index
- cm_tag  in  N_CM*TAG_W  retiring ROB tag
- flush  in  1  discard all speculative mappings
- ckpt_save  in  1  snapshot the table
- ckpt_restore  in  1  restore table from snapshot
- ckpt_valid  out  1  snapshot held

## Operation
- State per entry: busy bit and tag. Entry 0 is constant busy=0, tag=0.
- Source lookup (combinational) for slot j, source s:
  - If any older slot i<j has rn_valid, dest!=0 and dest==s, use the youngest such i: busy=1, tag=rn_tag[i].
  - Else read the table. Same-cycle commits are not visible to the lookup; the ROB wakeup covers that case.
  - s==0 gives busy=0, tag=0.
  - Outputs are computed regardless of rn_valid.
- Next-state, applied in this order:
  1. Commit: for each valid port j with cm_dest!=0, the entry is cleared (busy=0, tag=0) only if it is busy and tag==cm_tag[j]. On a mismatch there is no change.
  2. Rename: for each valid slot with dest!=0, set busy=1, tag=rn_tag. When slots share a dest, the youngest slot wins. A rename overrides a same-cycle commit clear of the same entry.
- flush: table goes to all busy=0/tag=0. Renames and commits that cycle are ignored. ckpt_valid is cleared.
- ckpt_restore with ckpt_valid=1: table := snapshot with this cycle's commit clears applied. Renames that cycle are dropped. ckpt_valid is cleared.
- ckpt_restore with ckpt_valid=0: no effect; the cycle proceeds normally.
- ckpt_save: snapshot := full next-state, including this cycle's commits and all renames. Sets ckpt_valid. Overwrites any prior snapshot.
- Priority: flush > ckpt_restore > ckpt_save. Save in the same cycle as a restore or flush is ignored.
- While ckpt_valid=1, the commit-clear rule is also applied to the snapshot every cycle, so a restore never resurrects a retired tag.

## Timing
- Lookup outputs are combinational from current state and rn_* inputs: zero-cycle latency.
- Table, snapshot and ckpt_valid update on the rising clk edge after the request cycle. Next-cycle lookups see the update.
- Reset (async, rst=0): all busy=0, all tags=0, snapshot cleared, ckpt_valid=0. Outputs: rs_/rt_busy=0 and rs_/rt_tag=0 for all slots.
- Reset mid-operation wipes all pending renames immediately; no partial update survives.
- No stall or handshake: the upstream ROB guarantees rn_tag uniqueness and free-entry availability.

## Configuration
- RAT_CHECKPOINT_EN defined: snapshot storage, ckpt_save, ckpt_restore and ckpt_valid behave as above.
- Undefined: there is no snapshot storage. ckpt_save and ckpt_restore are ignored, and ckpt_valid is tied 0. Recovery is by flush only.

## Test plan
- Reset then lookup: rn_rs=5, rn_rt=0 → busy=0, tag=0. Cycle with slot0 dest=5 tag=9, then next-cycle lookup of 5 → busy=1, tag=9.
- Intra-group bypass: slot0 dest=3 tag=4; slot1 rs=3, rt=7 → slot1 rs_busy=1, rs_tag=4, rt from table. Both slots dest=8 (tags 10, 11) → entry 8 holds tag 11.
- Stale commit: r5 renamed to tag 9, then tag 12. Commit (5,9) leaves busy=1, tag=12; commit (5,12) clears it. Same-cycle commit (5,12) plus rename dest=5 tag=13 → tag 13, busy=1.
- Dest 0: rename dest=0 tag=6 → entry 0 stays busy=0; rs=0 lookup gives busy=0.
- Checkpoint (RAT_CHECKPOINT_EN): map r2→t1, save, map r2→t3 and r4→t5, commit (2,1), restore → r2 busy=0, r4 busy=0, ckpt_valid=0. Repeat with flush asserted alongside restore → all entries clear.
- Async reset asserted mid-cycle with renames pending → all outputs 0 immediately; ckpt_valid=0.
